// File: rtl/spwm_generator_if.sv
// Bundle between the frequency selector and the SPWM generator: the selector
// supplies the per-quadrant tick count and phase increment, the generator
// returns the gate drives plus quadrant/magnitude status.
interface spwm_generator_if;
    logic [10:0] Ciclos_pwm;
    logic [16:0] Cte;
    logic        PWM_P;
    logic        PWM_N;
    logic [7:0]  Magnitud;
    logic [1:0]  Cuadrante;
    logic        Sync;

    // Upstream side: drives the step parameters, observes the generator.
    modport master (
        output Ciclos_pwm, Cte,
        input  PWM_P, PWM_N, Magnitud, Cuadrante, Sync
    );

    // Generator side: consumes the step parameters, drives the bridge outputs.
    modport slave (
        input  Ciclos_pwm, Cte,
        output PWM_P, PWM_N, Magnitud, Cuadrante, Sync
    );
endinterface

// File: rtl/spwm_generator.sv
// Unipolar SPWM generator: steps a saturating quarter-wave phase through four
// quadrants, looks the magnitude up in a quarter-sine ROM and compares it with
// an 8-bit triangle carrier to produce the positive/negative gate drives.
module spwm_generator #(
    parameter int TICK_DIV    = 10000,
    parameter int CARRIER_DIV = 1,
    parameter int PHASE_MAX   = 9999
) (
    input  logic             clock,
    input  logic             reset,
    spwm_generator_if.slave  bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_DIV - 1);
    localparam logic [16:0]   PH_MAX    = 17'(PHASE_MAX);

    // Quarter-sine table: entry i = round(255*sin(pi/2*min(i*128,9999)/9999)).
    function automatic logic [7:0] sine_rom(input logic [6:0] idx);
        logic [7:0] v;
        case (idx)
            7'd0:  v = 8'd0;   7'd1:  v = 8'd5;   7'd2:  v = 8'd10;  7'd3:  v = 8'd15;
            7'd4:  v = 8'd20;  7'd5:  v = 8'd26;  7'd6:  v = 8'd31;  7'd7:  v = 8'd36;
            7'd8:  v = 8'd41;  7'd9:  v = 8'd46;  7'd10: v = 8'd51;  7'd11: v = 8'd56;
            7'd12: v = 8'd61;  7'd13: v = 8'd66;  7'd14: v = 8'd71;  7'd15: v = 8'd76;
            7'd16: v = 8'd81;  7'd17: v = 8'd85;  7'd18: v = 8'd90;  7'd19: v = 8'd95;
            7'd20: v = 8'd100; 7'd21: v = 8'd105; 7'd22: v = 8'd109; 7'd23: v = 8'd114;
            7'd24: v = 8'd118; 7'd25: v = 8'd123; 7'd26: v = 8'd127; 7'd27: v = 8'd132;
            7'd28: v = 8'd136; 7'd29: v = 8'd140; 7'd30: v = 8'd145; 7'd31: v = 8'd149;
            7'd32: v = 8'd153; 7'd33: v = 8'd157; 7'd34: v = 8'd161; 7'd35: v = 8'd165;
            7'd36: v = 8'd169; 7'd37: v = 8'd173; 7'd38: v = 8'd176; 7'd39: v = 8'd180;
            7'd40: v = 8'd184; 7'd41: v = 8'd187; 7'd42: v = 8'd191; 7'd43: v = 8'd194;
            7'd44: v = 8'd197; 7'd45: v = 8'd201; 7'd46: v = 8'd204; 7'd47: v = 8'd207;
            7'd48: v = 8'd210; 7'd49: v = 8'd213; 7'd50: v = 8'd215; 7'd51: v = 8'd218;
            7'd52: v = 8'd221; 7'd53: v = 8'd223; 7'd54: v = 8'd226; 7'd55: v = 8'd228;
            7'd56: v = 8'd230; 7'd57: v = 8'd232; 7'd58: v = 8'd234; 7'd59: v = 8'd236;
            7'd60: v = 8'd238; 7'd61: v = 8'd240; 7'd62: v = 8'd242; 7'd63: v = 8'd243;
            7'd64: v = 8'd245; 7'd65: v = 8'd246; 7'd66: v = 8'd247; 7'd67: v = 8'd249;
            7'd68: v = 8'd250; 7'd69: v = 8'd251; 7'd70: v = 8'd252; 7'd71: v = 8'd252;
            7'd72: v = 8'd253; 7'd73: v = 8'd254; 7'd74: v = 8'd254; 7'd75: v = 8'd254;
            default: v = 8'd255;   // 76..79 and anything beyond sit at the crest
        endcase
        return v;
    endfunction

    logic [TW-1:0] r_tick_cnt;
    logic [10:0]   r_step;
    logic [16:0]   r_phase;
    logic [1:0]    r_quad;
    logic [10:0]   r_nq_sh;
    logic [16:0]   r_cte_sh;
    logic          r_sync;
    logic [7:0]    r_mag;
    logic [1:0]    r_cuad;
    logic [CW-1:0] r_car_cnt;
    logic [7:0]    r_carrier;
    logic          r_car_up;
    logic          r_pwm_p;
    logic          r_pwm_n;

    logic          w_tick;
    logic [10:0]   w_nq;
    logic          w_qend;
    logic [17:0]   w_sum;
    logic [16:0]   w_sat;
    logic [16:0]   w_fold;
    logic [6:0]    w_idx;
    logic          w_car_step;

    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_nq       = (r_nq_sh == 11'd0) ? 11'd1 : r_nq_sh;   // zero ticks would never end
    assign w_qend     = w_tick && (r_step == (w_nq - 11'd1));
    // 18-bit sum so a large increment saturates instead of wrapping.
    assign w_sum      = {1'b0, r_phase} + {1'b0, r_cte_sh};
    assign w_sat      = (w_sum > 18'(PHASE_MAX)) ? PH_MAX : w_sum[16:0];
    // Odd quadrants run the quarter-wave backwards.
    assign w_fold     = r_quad[0] ? (PH_MAX - r_phase) : r_phase;
    assign w_idx      = 7'(w_fold >> 7);
    assign w_car_step = (r_car_cnt == CAR_LAST);

    // Phase-step tick prescaler.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Step counter, saturating phase accumulator, quadrant and shadow parameters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_step   <= 11'd0;
            r_phase  <= 17'd0;
            r_quad   <= 2'd0;
            r_nq_sh  <= bus.Ciclos_pwm;
            r_cte_sh <= bus.Cte;
        end else if (w_qend) begin
            r_step   <= 11'd0;
            r_phase  <= 17'd0;
            r_quad   <= r_quad + 2'd1;
            r_nq_sh  <= bus.Ciclos_pwm;
            r_cte_sh <= bus.Cte;
        end else if (w_tick) begin
            r_step   <= r_step + 11'd1;
            r_phase  <= w_sat;
        end else begin
            r_step   <= r_step;
            r_phase  <= r_phase;
        end
    end

    // One-clock period marker when quadrant 3 rolls over to quadrant 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= 1'b0;
        end else begin
            r_sync <= w_qend && (r_quad == 2'd3);
        end
    end

    // Registered magnitude lookup with its quadrant kept alongside.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mag  <= 8'd0;
            r_cuad <= 2'd0;
        end else begin
            r_mag  <= sine_rom(w_idx);
            r_cuad <= r_quad;
        end
    end

    // Symmetric up/down triangle carrier; each extreme is held for one step.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_car_cnt <= '0;
            r_carrier <= 8'd0;
            r_car_up  <= 1'b1;
        end else if (w_car_step) begin
            r_car_cnt <= '0;
            if (r_car_up) begin
                if (r_carrier == 8'd255) begin
                    r_carrier <= 8'd254;
                    r_car_up  <= 1'b0;
                end else begin
                    r_carrier <= r_carrier + 8'd1;
                end
            end else begin
                if (r_carrier == 8'd0) begin
                    r_carrier <= 8'd1;
                    r_car_up  <= 1'b1;
                end else begin
                    r_carrier <= r_carrier - 8'd1;
                end
            end
        end else begin
            r_car_cnt <= r_car_cnt + CW'(1);
        end
    end

    // Gate drive compare; quadrant MSB picks the half-cycle so both never fire.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pwm_p <= 1'b0;
            r_pwm_n <= 1'b0;
        end else begin
            r_pwm_p <= ~r_cuad[1] && (r_mag > r_carrier);
            r_pwm_n <=  r_cuad[1] && (r_mag > r_carrier);
        end
    end

    assign bus.PWM_P     = r_pwm_p;
    assign bus.PWM_N     = r_pwm_n;
    assign bus.Magnitud  = r_mag;
    assign bus.Cuadrante = r_cuad;
    assign bus.Sync      = r_sync;
endmodule
